// File: rtl/ita_softmax_ctrl.sv
// Softmax sequencer: credit-gated QK accumulation, division wait, stream read.
// Optional stall counter enabled by defining ITA_SOFTMAX_CTRL_PERF_EN.
module ita_softmax_ctrl #(
   parameter int unsigned M             = 64,
   parameter int unsigned N             = 16,
   parameter int unsigned SoftFifoDepth = 4,
   parameter int unsigned CntWidth      = 16
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                start_i,
   input  logic [CntWidth-1:0] tile_s_i,
   input  logic                qk_valid_i,
   output logic                qk_ready_o,
   output logic                calc_en_o,
   input  logic                pop_fifo_i,
   input  logic                softmax_done_i,
   input  logic                stream_ready_i,
   output logic                calc_stream_soft_en_o,
   output logic                busy_o,
   output logic                done_o,
   output logic [31:0]         stall_cnt_o
);

   localparam int unsigned B   = M * M / N;
   localparam int unsigned CrW = $clog2(SoftFifoDepth + 1);

   localparam logic [CntWidth-1:0] One   = CntWidth'(1);
   localparam logic [CntWidth-1:0] BLast = CntWidth'(B - 1);
   localparam logic [CntWidth-1:0] BPush = CntWidth'(B - M);
   localparam logic [CrW-1:0]      CrOne = CrW'(1);
   localparam logic [CrW-1:0]      CrMax = CrW'(SoftFifoDepth);

   typedef enum logic [1:0] {
      Idle,
      Accum,
      WaitDiv,
      Stream
   } state_e;

   state_e              state_q;
   logic [CntWidth-1:0] count_q, tile_q, tile_s_q, scnt_q;
   logic [CrW-1:0]      credits_q, credits_d;
   logic                done_seen_q;

   logic last_tile, push_nxt, accept, push_acc;
   logic start_acc, stream_en, last_beat;

   assign start_acc = (state_q == Idle) & start_i;
   assign last_tile = (tile_q == tile_s_q - One);
   assign last_beat = (count_q == BLast);
   // the next beat of the last tile feeds a row into the division FIFO
   assign push_nxt  = last_tile & (count_q >= BPush);

   assign qk_ready_o = (state_q == Accum) &
                       ~(push_nxt & (credits_q == '0));
   assign accept     = qk_valid_i & qk_ready_o;
   assign push_acc   = accept & push_nxt;
   assign calc_en_o  = accept;

   assign stream_en             = (state_q == Stream) & stream_ready_i;
   assign calc_stream_soft_en_o = stream_en;
   assign done_o                = stream_en & (scnt_q == BLast);
   assign busy_o                = (state_q != Idle);

   // credit bookkeeping; a pop at full credits has nothing to return
   always_comb begin
      credits_d = credits_q;
      if (start_acc) begin
         credits_d = CrMax;
      end else if (push_acc && !pop_fifo_i) begin
         credits_d = credits_q - CrOne;
      end else if (pop_fifo_i && !push_acc && credits_q != CrMax) begin
         credits_d = credits_q + CrOne;
      end
   end

   // pass sequencing and beat counters
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= Idle;
         count_q     <= '0;
         tile_q      <= '0;
         tile_s_q    <= '0;
         scnt_q      <= '0;
         credits_q   <= CrMax;
         done_seen_q <= 1'b0;
      end else begin
         credits_q <= credits_d;
         case (state_q)
            Idle: begin
               if (start_i) begin
                  state_q     <= Accum;
                  tile_s_q    <= (tile_s_i == '0) ? One : tile_s_i;
                  count_q     <= '0;
                  tile_q      <= '0;
                  scnt_q      <= '0;
                  done_seen_q <= 1'b0;
               end
            end
            Accum: begin
               if (softmax_done_i) done_seen_q <= 1'b1;
               if (accept) begin
                  if (last_beat) begin
                     count_q <= '0;
                     tile_q  <= tile_q + One;
                     if (last_tile) state_q <= WaitDiv;
                  end else begin
                     count_q <= count_q + One;
                  end
               end
            end
            WaitDiv: begin
               if (done_seen_q || softmax_done_i) begin
                  state_q     <= Stream;
                  done_seen_q <= 1'b0;
               end
            end
            Stream: begin
               if (stream_en) begin
                  scnt_q <= scnt_q + One;
                  if (scnt_q == BLast) state_q <= Idle;
               end
            end
            default: state_q <= Idle;
         endcase
      end
   end

   a_pop_overflow: assert property (
      @(posedge clk_i) disable iff (!rst_ni)
      !(pop_fifo_i && (credits_q == CrMax) && !push_acc));

`ifdef ITA_SOFTMAX_CTRL_PERF_EN
   logic [31:0] stall_q;

   // saturating count of accumulation cycles lost to missing credits
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stall_q <= '0;
      end else if (start_acc) begin
         stall_q <= '0;
      end else if ((state_q == Accum) && qk_valid_i && !qk_ready_o &&
                   (stall_q != '1)) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign stall_cnt_o = stall_q;
`else
   assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ita_softmax_ctrl.sv
// Directed bench for ita_softmax_ctrl.
// Table vectors for the start-up cycles plus hand sequences for whole passes.
module tb_ita_softmax_ctrl;

   localparam int B = 256;
   localparam int M = 64;
`ifdef ITA_SOFTMAX_CTRL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_i, qk_valid_i, pop_fifo_i;
   logic        softmax_done_i, stream_ready_i;
   logic [15:0] tile_s_i;
   logic        qk_ready_o, calc_en_o, calc_stream_soft_en_o;
   logic        busy_o, done_o;
   logic [31:0] stall_cnt_o;

   always #5 clk = ~clk;

   ita_softmax_ctrl dut (
      .clk_i                 (clk),
      .rst_ni                (rst_n),
      .start_i               (start_i),
      .tile_s_i              (tile_s_i),
      .qk_valid_i            (qk_valid_i),
      .qk_ready_o            (qk_ready_o),
      .calc_en_o             (calc_en_o),
      .pop_fifo_i            (pop_fifo_i),
      .softmax_done_i        (softmax_done_i),
      .stream_ready_i        (stream_ready_i),
      .calc_stream_soft_en_o (calc_stream_soft_en_o),
      .busy_o                (busy_o),
      .done_o                (done_o),
      .stall_cnt_o           (stall_cnt_o)
   );

   typedef struct {
      bit          st;
      logic [15:0] ts;
      bit          v, sd, sr;
      logic [4:0]  exp; // {ready, calc, stream, busy, done}
   } vec_t;

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;
   int bidx = 0;
   int ts_m = 1;
   int owed = 0;
   bit auto_pop = 1'b0;
   int popq[$];

   logic        s_ready, s_calc, s_sen, s_busy, s_done;
   logic [31:0] s_stall;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic bit is_push(input int idx);
      return ((idx / B) == ts_m - 1) && ((idx % B) >= B - M);
   endfunction

   // one clock: drive, settle, sample, advance past the edge
   task automatic step(input bit st, input logic [15:0] ts, input bit v,
                       input bit sd, input bit sr, input bit pr);
      bit p;
      int tmp;
      p = pr;
      if (!p && popq.size() > 0 && popq[0] <= cyc) begin
         p   = 1'b1;
         tmp = popq.pop_front();
      end
      start_i        = st;
      tile_s_i       = ts;
      qk_valid_i     = v;
      softmax_done_i = sd;
      stream_ready_i = sr;
      pop_fifo_i     = p;
      #1;
      s_ready = qk_ready_o;
      s_calc  = calc_en_o;
      s_sen   = calc_stream_soft_en_o;
      s_busy  = busy_o;
      s_done  = done_o;
      s_stall = stall_cnt_o;
      if (pr && owed > 0) owed--;
      if (s_calc) begin
         if (is_push(bidx)) begin
            if (auto_pop) popq.push_back(cyc + 2);
            else owed++;
         end
         bidx++;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_accum(input int upto, input int budget,
                            output int cycles, output int stalls);
      cycles = 0;
      stalls = 0;
      for (int i = 0; i < budget; i++) begin
         if (bidx == upto) break;
         step(1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);
         cycles++;
         if (!s_ready) stalls++;
      end
   endtask

   task automatic flush_owed();
      while (owed > 0) begin
         popq.push_back(cyc);
         owed--;
      end
   endtask

   task automatic run_stream(input bit toggle, input string nm);
      int n, dn, dat;
      bit first;
      n = 0; dn = 0; dat = 0; first = 1'b0;
      for (int i = 0; i < 700; i++) begin
         if (n == B) break;
         step(1'b0, 16'd0, 1'b0, 1'b0, toggle ? (i % 2 == 0) : 1'b1, 1'b0);
         if (i == 0) first = s_sen;
         if (s_sen) n++;
         if (s_done) begin
            dn++;
            dat = n;
         end
      end
      chk({nm, " first stream beat"}, 32'(first), 32'd1);
      chk({nm, " stream beats"}, n, B);
      chk({nm, " done pulses"}, dn, 1);
      chk({nm, " done on last beat"}, dat, B);
      step(1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk({nm, " idle after done"}, {s_busy, s_done, s_sen}, 3'b000);
   endtask

   task automatic start_pass(input logic [15:0] ts, input bit ap);
      step(1'b1, ts, 1'b0, 1'b0, 1'b0, 1'b0);
      bidx     = 0;
      ts_m     = (ts == 0) ? 1 : int'(ts);
      auto_pop = ap;
      owed     = 0;
   endtask

   task automatic do_reset();
      rst_n          = 1'b0;
      qk_valid_i     = 1'b1;
      stream_ready_i = 1'b1;
      popq.delete();
      owed = 0;
      #1;
      chk("reset outputs",
          {qk_ready_o, calc_en_o, calc_stream_soft_en_o, busy_o, done_o},
          5'b00000);
      chk("reset stall_cnt", stall_cnt_o, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   vec_t tbl[8];
   int   cy, stl;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 5'b00000};
      tbl[1] = '{1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 5'b00000};
      tbl[2] = '{1'b1, 16'd1, 1'b1, 1'b0, 1'b0, 5'b00000};
      tbl[3] = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 5'b10010};
      tbl[4] = '{1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 5'b11010};
      tbl[5] = '{1'b1, 16'd7, 1'b1, 1'b0, 1'b0, 5'b11010};
      tbl[6] = '{1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 5'b10010};
      tbl[7] = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 5'b10010};

      rst_n = 1'b0;
      start_i = 1'b0; tile_s_i = '0; qk_valid_i = 1'b0;
      pop_fifo_i = 1'b0; softmax_done_i = 1'b0; stream_ready_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset state",
          {qk_ready_o, calc_en_o, calc_stream_soft_en_o, busy_o, done_o},
          5'b00000);
      chk("reset stall_cnt", stall_cnt_o, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // start-up vectors; vector 6 leaves an early done latched
      bidx = 0; ts_m = 1; auto_pop = 1'b0;
      foreach (tbl[i]) begin
         step(tbl[i].st, tbl[i].ts, tbl[i].v, tbl[i].sd, tbl[i].sr, 1'b0);
         chk($sformatf("tbl[%0d]", i),
             {s_ready, s_calc, s_sen, s_busy, s_done}, tbl[i].exp);
      end

      // credit stall: no pops, ready falls after beat 195
      run_accum(100000, 250, cy, stl);
      chk("stall accepted beats", bidx, 196);
      chk("stall cycles", stl, 56);
      chk("stall ready low", {s_ready, s_busy}, 2'b01);
      step(1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("pop cycle still stalled", s_ready, 1'b0);
      run_accum(100000, 10, cy, stl);
      chk("one beat per pop", bidx, 197);
      step(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("stall_cnt after pop", s_stall, PERF ? 32'd66 : 32'd0);

      // finish with early done already latched
      auto_pop = 1'b1;
      flush_owed();
      run_accum(B, 400, cy, stl);
      chk("early pass beats", bidx, B);
      step(1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("early wait_div",
          {s_ready, s_calc, s_sen, s_busy}, 4'b0001);
      run_stream(1'b0, "early");

      // single tile with pops two cycles after each push
      start_pass(16'd1, 1'b1);
      run_accum(B, 400, cy, stl);
      chk("single beats", bidx, B);
      chk("single cycles", cy, B);
      chk("single stalls", stl, 0);
      step(1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("single wait_div", {s_ready, s_calc, s_sen, s_busy}, 4'b0001);
      chk("single stall_cnt cleared", s_stall, 32'd0);
      step(1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("single still waiting", {s_sen, s_busy}, 2'b01);
      step(1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("single done cycle", {s_sen, s_busy}, 2'b01);
      run_stream(1'b0, "single");

      // three tiles, no pops until the last tile stalls
      start_pass(16'd3, 1'b0);
      run_accum(100000, 800, cy, stl);
      chk("multi beats before stall", bidx, 2 * B + 196);
      chk("multi stalls", stl, 800 - (2 * B + 196));
      auto_pop = 1'b1;
      flush_owed();
      run_accum(3 * B, 600, cy, stl);
      chk("multi total beats", bidx, 3 * B);
      step(1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("multi wait_div", {s_ready, s_sen, s_busy}, 3'b001);
      step(1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("multi done cycle", s_sen, 1'b0);
      run_stream(1'b1, "multi toggle");

      // tile_s = 0 runs as one tile; start while busy is ignored
      start_pass(16'd0, 1'b1);
      run_accum(100000, 260, cy, stl);
      chk("tile0 beats", bidx, B);
      chk("tile0 ready low", {s_ready, s_busy}, 2'b01);
      step(1'b1, 16'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("busy start busy", {s_calc, s_busy}, 2'b01);
      step(1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("busy start ignored", {s_ready, s_calc, s_busy}, 3'b001);
      do_reset();

      // reset mid-accumulation
      start_pass(16'd1, 1'b1);
      run_accum(10, 40, cy, stl);
      chk("pre-reset beats", bidx, 10);
      do_reset();
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0);
         chk($sformatf("post-reset idle %0d", i),
             {s_ready, s_calc, s_sen, s_busy, s_done}, 5'b00000);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/ita_softmax_ctrl.md
# ita_softmax_ctrl

Sequencer for the softmax unit. It gates the QK accumulation beats into the softmax pipeline, holding them back with credit-based backpressure so the division FIFO is never overrun. It then waits for all row divisions to finish and issues the stream-softmax read beats. It sits between the main ITA controller (start/step handshake) and the softmax datapath.

## Interface
Parameters:
- `M`, 64, tile edge; rows per softmax block
- `N`, 16, elements per accumulation beat
- `SoftFifoDepth`, 4, entries in the softmax division FIFO
- `CntWidth`, 16, width of count/tile counters and `tile_s_i`

Ports:
- `clk_i`  in  1  clock
- `rst_ni`  in  1  asynchronous active-low reset
- `start_i`  in  1  one-cycle start of a QK softmax pass; ignored unless idle
- `tile_s_i`  in  CntWidth  number of tiles in the pass; sampled on the accepted start
- `qk_valid_i`  in  1  requantized QK beat available
- `qk_ready_o`  out  1  beat may be accepted
- `calc_en_o`  out  1  accumulation enable to the datapath (= accepted beat)
- `pop_fifo_i`  in  1  datapath popped one entry from the division FIFO
- `softmax_done_i`  in  1  pulse: all M row divisions written back
- `stream_ready_i`  in  1  consumer can accept a stream-softmax beat
- `calc_stream_soft_en_o`  out  1  stream read enable to the datapath
- `busy_o`  out  1  pass in progress
- `done_o`  out  1  one-cycle pulse on the final stream beat
- `stall_cnt_o`  out  32  credit-stall cycle counter (see Configuration)

## Operation
- Defined constant: B = M*M/N beats per tile (256 at the defaults).
- States:
  - IDLE: accepted `start_i` → ACCUM. At the same time, latch `tile_s` (a value of 0 is treated as 1), clear `count`, `tile`, `done_seen` and `scnt`, and set credits = SoftFifoDepth.
  - ACCUM: `calc_en_o = qk_valid_i & qk_ready_o`.
    - Each accepted beat increments `count`. At B-1, `count` wraps to 0 and `tile` increments.
    - Accepting the beat with `tile == tile_s-1` and `count == B-1` → WAIT_DIV.
  - WAIT_DIV: `qk_ready_o = 0`. Transition → STREAM when `done_seen | softmax_done_i`.
  - STREAM: `calc_stream_soft_en_o = stream_ready_i`.
    - Each issued beat increments `scnt`.
    - The beat with `scnt == B-1` pulses `done_o` and transitions → IDLE.
- Push beat: an accepted beat with `tile == tile_s-1` and `count >= B-M`. Each push beat produces exactly one FIFO push three cycles later.
- Credits (width $clog2(SoftFifoDepth+1)):
  - Decrement on each accepted push beat.
  - Increment on each `pop_fifo_i`.
  - A same-cycle accept and pop leaves credits unchanged.
  - Credits never exceed SoftFifoDepth. A pop arriving at the maximum is ignored, and an SVA assertion flags it.
- `qk_ready_o = (state == ACCUM) & !(next beat is a push beat & credits == 0)`. Only the registered credit value is used; there is no combinational path from `pop_fifo_i`.
- `done_seen` sets on `softmax_done_i` in ACCUM or WAIT_DIV and clears on leaving WAIT_DIV. An early done is therefore never lost.
- `busy_o = (state != IDLE)`.
- `start_i` outside IDLE is ignored.
- `softmax_done_i` in IDLE or STREAM is ignored.

## Timing
- Reset: state IDLE, all counters 0, credits = SoftFifoDepth. All outputs are 0, including `stall_cnt_o`.
- Reset mid-pass returns the block to IDLE immediately. No partial beats are issued after `rst_ni` deasserts.
- Start to first possible `calc_en_o`: 1 cycle (the cycle after the accepted `start_i`).
- `calc_en_o` and `calc_stream_soft_en_o` are combinational from registered state plus `qk_valid_i` / `stream_ready_i`. `qk_ready_o` depends on registered state only.
- WAIT_DIV → STREAM: the first stream beat can be issued the cycle after `softmax_done_i` (or directly on entry if `done_seen` is already set).
- `done_o` is asserted in the same cycle as the last `calc_stream_soft_en_o`. `busy_o` falls the following cycle.
- Sustained throughput: 1 beat per cycle when credits are available and `qk_valid_i` / `stream_ready_i` are held high.

## Configuration
- `ITA_SOFTMAX_CTRL_PERF_EN`:
  - Defined: `stall_cnt_o` counts the cycles in ACCUM with `qk_valid_i & !qk_ready_o`. It clears on an accepted start and saturates at 2^32-1.
  - Undefined: the counter logic is removed and `stall_cnt_o` is tied to 0.

## Test plan
- Single tile: `tile_s_i = 1`, valid held high, a pop issued 2 cycles after each push → 256 `calc_en_o` pulses, no stalls, WAIT_DIV entered after beat 255, `softmax_done_i` → 256 stream beats, then one `done_o` pulse.
- Credit stall: `tile_s_i = 1`, no pops → `qk_ready_o` drops after beat 195 (the 4th push beat, count 192..195). A single `pop_fifo_i` → exactly one further beat accepted; with PERF_EN defined, `stall_cnt_o` equals the stall cycles.
- Multi-tile: `tile_s_i = 3` → no credits consumed in tiles 0-1; the stall behaviour appears only in tile 2; total 768 `calc_en_o` pulses.
- Early done: `softmax_done_i` pulsed during ACCUM → latched; the first stream beat is issued on the cycle after WAIT_DIV is entered.
- Stream backpressure: `stream_ready_i` toggling 1/0 → exactly 256 `calc_stream_soft_en_o` pulses, and `done_o` coincides with the 256th.
- Reset and degenerate cases: reset asserted mid-ACCUM → all outputs 0 and IDLE; `start_i` while busy ignored; `tile_s_i = 0` behaves as 1.
